// File: rtl/si_statistics_poller_wb.sv
// Wishbone initiator: probes the statistics responder, streams registers 12..48 as one AXI-Stream record, optionally clears them.
// Zero-wait responder with tready high: 4 cycles per word, start to done under 50 cycles; holds tdata/tlast while tready is low.
module si_statistics_poller_wb #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter logic [7:0]  BASE_ADR    = 8'h00
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        start,
    input  logic [2:0]  clear_mask,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [7:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast
);

    typedef enum logic [2:0] {IDLE, PROBE, READ, PUSH, CLEAR, DONE} state_t;

    localparam logic [15:0] TMO_LAST  = 16'(ACK_TIMEOUT - 1);
    localparam logic [7:0]  LAST_OFS  = 8'd48;

    state_t      state;
    logic [7:0]  offset;
    logic [2:0]  mask;
    logic [15:0] timer;
    logic [7:0]  acc_adr;

    always_comb begin
        acc_adr = BASE_ADR;
        case (state)
            READ:    acc_adr = BASE_ADR + offset;
            CLEAR:   acc_adr = BASE_ADR + 8'd8;
            default: acc_adr = BASE_ADR;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state         <= IDLE;
            offset        <= 8'd0;
            mask          <= 3'd0;
            timer         <= 16'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_code      <= 2'd0;
            wb_adr_o      <= 8'd0;
            wb_dat_o      <= 32'd0;
            wb_we_o       <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_cyc_o      <= 1'b0;
            m_axis_tdata  <= 32'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= PROBE;
                        busy     <= 1'b1;
                        mask     <= clear_mask;
                        err_code <= 2'd0;
                    end
                end
                PROBE, READ, CLEAR: begin
                    // Every access state is entered with stb low, which gives the idle gap between accesses.
                    if (!wb_stb_o) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_adr_o <= acc_adr;
                        timer    <= 16'd0;
                        if (state == CLEAR) begin
                            wb_we_o  <= 1'b1;
                            wb_dat_o <= {29'd0, mask};
                        end
                    end else if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_dat_o <= 32'd0;
                        case (state)
                            PROBE: begin
                                if (wb_dat_i == 32'd1) begin
                                    state  <= READ;
                                    offset <= 8'd12;
                                end else begin
                                    err_code <= 2'd1;
                                    state    <= DONE;
                                    done     <= 1'b1;
                                    busy     <= 1'b0;
                                end
                            end
                            READ: begin
                                m_axis_tdata  <= wb_dat_i;
                                m_axis_tlast  <= (offset == LAST_OFS);
                                m_axis_tvalid <= 1'b1;
                                state         <= PUSH;
                            end
                            default: begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        endcase
                    end else if (timer == TMO_LAST) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_dat_o <= 32'd0;
                        err_code <= 2'd2;
                        state    <= DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                PUSH: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        if (offset == LAST_OFS) begin
                            if (mask != 3'd0) begin
                                state <= CLEAR;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else begin
                            offset <= offset + 8'd4;
                            state  <= READ;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_si_statistics_poller_wb.sv
// Directed bench for si_statistics_poller_wb with a behavioural Wishbone responder and stream monitor.
module tb_si_statistics_poller_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  clear_mask;
    logic        busy, done;
    logic [1:0]  err_code;
    logic [7:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic [31:0] wb_dat_i = 32'd0;
    logic        wb_ack_i = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;

    // stimulus knobs
    logic        tready_base, toggle_mode, hold2;
    logic        tog = 1'b1;
    int          tcnt = 0;
    logic [31:0] probe_val;
    logic [7:0]  no_ack_adr;

    // observation state
    int          errors = 0, checks = 0;
    int          cyc_n = 0, last_ack_cyc = 0, done_cyc = 0, start_cyc = 0;
    int          done_cnt = 0, tvalid_cnt = 0, stb28 = 0, bad_we = 0;
    int          stall_err = 0, stalls = 0;
    int          wr_cnt = 0;
    logic [7:0]  wr_adr = 8'd0;
    logic [31:0] wr_dat = 32'd0;
    logic        ack_left = 1'b0;
    logic        hold_vld = 1'b0, hold_last = 1'b0;
    logic [31:0] hold_dat = 32'd0;
    logic [31:0] beats[$];
    logic        lasts[$];

    assign m_axis_tready = toggle_mode ? tog : tready_base;

    si_statistics_poller_wb #(.ACK_TIMEOUT(255), .BASE_ADR(8'h00)) dut (
        .wb_clk(clk), .wb_rst(rst), .start(start), .clear_mask(clear_mask),
        .busy(busy), .done(done), .err_code(err_code),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tcnt == 2) begin
            tcnt = 0;
            tog  = ~tog;
        end else begin
            tcnt = tcnt + 1;
        end
    end

    function automatic logic [31:0] reg_val(input logic [7:0] a);
        return (a == 8'd0) ? probe_val : {20'd0, a, 4'd0};
    endfunction

    // Responder: registered ack one cycle after stb, optionally held one extra cycle.
    always @(posedge clk) begin
        if (rst) begin
            wb_ack_i <= 1'b0;
            ack_left <= 1'b0;
        end else if (wb_cyc_o && wb_stb_o && !wb_ack_i && wb_adr_o != no_ack_adr) begin
            wb_ack_i <= 1'b1;
            wb_dat_i <= reg_val(wb_adr_o);
            ack_left <= hold2;
        end else if (wb_ack_i && ack_left) begin
            ack_left <= 1'b0;
        end else begin
            wb_ack_i <= 1'b0;
        end
        if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i) begin
            wr_cnt <= wr_cnt + 1;
            wr_adr <= wb_adr_o;
            wr_dat <= wb_dat_o;
        end
    end

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (wb_stb_o && wb_ack_i) last_ack_cyc <= cyc_n;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc_n;
        end
        if (start && !busy && !rst) start_cyc <= cyc_n;
        if (m_axis_tvalid) tvalid_cnt <= tvalid_cnt + 1;
        if (m_axis_tvalid && m_axis_tready) begin
            beats.push_back(m_axis_tdata);
            lasts.push_back(m_axis_tlast);
        end
        if (wb_stb_o && wb_adr_o == 8'd28) stb28 <= stb28 + 1;
        if ((wb_we_o && wb_adr_o != 8'd8) || (!wb_we_o && wb_dat_o != 32'd0)) bad_we <= bad_we + 1;
        if (!rst && hold_vld &&
            (!m_axis_tvalid || m_axis_tdata != hold_dat || m_axis_tlast != hold_last))
            stall_err <= stall_err + 1;
        if (m_axis_tvalid && !m_axis_tready) stalls <= stalls + 1;
        hold_vld  <= !rst && m_axis_tvalid && !m_axis_tready;
        hold_dat  <= m_axis_tdata;
        hold_last <= m_axis_tlast;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, {31'd0, busy}, 0);
        check({tag, " done"}, {31'd0, done}, 0);
        check({tag, " err"}, {30'd0, err_code}, 0);
        check({tag, " adr"}, {24'd0, wb_adr_o}, 0);
        check({tag, " dat"}, wb_dat_o, 0);
        check({tag, " we"}, {31'd0, wb_we_o}, 0);
        check({tag, " stb"}, {31'd0, wb_stb_o}, 0);
        check({tag, " cyc"}, {31'd0, wb_cyc_o}, 0);
        check({tag, " tdata"}, m_axis_tdata, 0);
        check({tag, " tvalid"}, {31'd0, m_axis_tvalid}, 0);
        check({tag, " tlast"}, {31'd0, m_axis_tlast}, 0);
    endtask

    task automatic do_start(input logic [2:0] m);
        @(negedge clk);
        clear_mask = m;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        clear_mask = 3'd0;
    endtask

    task automatic wait_done(input int d0, input int bound, input string tag);
        int i;
        i = 0;
        while (done_cnt == d0 && i < bound) begin
            @(negedge clk);
            i++;
        end
        check({tag, " done pulse"}, done_cnt, d0 + 1);
    endtask

    task automatic check_record(input int base, input int n, input bit full, input string tag);
        check({tag, " beats"}, beats.size() - base, n);
        for (int i = 0; i < n && base + i < beats.size(); i++) begin
            check($sformatf("%s data%0d", tag, i), beats[base + i], (12 + 4 * i) * 16);
            check($sformatf("%s last%0d", tag, i), {31'd0, lasts[base + i]}, (full && i == 9) ? 1 : 0);
        end
    endtask

    initial begin
        int d0, b0, w0, s0, t0, k;
        rst = 1'b1; start = 1'b0; clear_mask = 3'd0;
        tready_base = 1'b1; toggle_mode = 1'b0; hold2 = 1'b0;
        probe_val = 32'd1; no_ack_adr = 8'hFF;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // full record, no clear
        d0 = done_cnt; b0 = beats.size(); w0 = wr_cnt;
        do_start(3'd0);
        check("t1 busy", {31'd0, busy}, 1);
        wait_done(d0, 200, "t1");
        check_record(b0, 10, 1'b1, "t1");
        check("t1 err", {30'd0, err_code}, 0);
        check("t1 writes", wr_cnt - w0, 0);
        check("t1 latency<=50", {31'd0, (done_cyc - start_cyc) <= 50}, 1);
        check("t1 done one cycle", {31'd0, done}, 0);
        check("t1 busy low", {31'd0, busy}, 0);

        // tready toggling, plus a start pulse while busy
        toggle_mode = 1'b1;
        d0 = done_cnt; b0 = beats.size(); s0 = stalls;
        do_start(3'd0);
        repeat (5) @(negedge clk);
        do_start(3'd0);
        wait_done(d0, 400, "t2");
        check_record(b0, 10, 1'b1, "t2");
        check("t2 stall stable", stall_err, 0);
        check("t2 stalls seen", {31'd0, stalls > s0}, 1);
        repeat (60) @(negedge clk);
        check("t2 no second sweep", done_cnt, d0 + 1);
        check("t2 busy idle", {31'd0, busy}, 0);
        toggle_mode = 1'b0;

        // responder absent
        probe_val = 32'd0;
        d0 = done_cnt; b0 = beats.size(); t0 = tvalid_cnt;
        do_start(3'd0);
        wait_done(d0, 100, "t3");
        check("t3 err", {30'd0, err_code}, 1);
        check("t3 no tvalid", tvalid_cnt - t0, 0);
        check("t3 done after probe ack", done_cyc - last_ack_cyc, 1);
        probe_val = 32'd1;

        // no ack at offset 28
        no_ack_adr = 8'd28;
        d0 = done_cnt; b0 = beats.size(); s0 = stb28;
        do_start(3'd0);
        wait_done(d0, 1000, "t4");
        check_record(b0, 4, 1'b0, "t4");
        check("t4 err", {30'd0, err_code}, 2);
        check("t4 stb cycles", stb28 - s0, 255);
        check("t4 cyc dropped", {31'd0, wb_cyc_o}, 0);
        no_ack_adr = 8'hFF;

        // clear write with a long ack
        hold2 = 1'b1;
        d0 = done_cnt; b0 = beats.size(); w0 = wr_cnt;
        do_start(3'b101);
        wait_done(d0, 200, "t5");
        check_record(b0, 10, 1'b1, "t5");
        check("t5 writes", wr_cnt - w0, 1);
        check("t5 write adr", {24'd0, wr_adr}, 8);
        check("t5 write dat", wr_dat, 5);
        check("t5 err", {30'd0, err_code}, 0);
        check("t5 done after write ack", done_cyc - last_ack_cyc, 1);
        repeat (5) @(negedge clk);
        check("t5 writes settled", wr_cnt - w0, 1);
        check("t5 we low", {31'd0, wb_we_o}, 0);
        hold2 = 1'b0;

        // reset during the fifth beat
        d0 = done_cnt; b0 = beats.size();
        do_start(3'd0);
        k = 0;
        while (!((beats.size() - b0) == 4 && m_axis_tvalid) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t6 reached beat 5", {31'd0, k < 200}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("t6 mid reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t6 no done", done_cnt, d0);
        d0 = done_cnt; b0 = beats.size();
        do_start(3'd0);
        wait_done(d0, 200, "t6");
        check_record(b0, 10, 1'b1, "t6");
        check("t6 err", {30'd0, err_code}, 0);

        check("we/dat outside clear", bad_we, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/si_statistics_poller_wb.md
Name: si_statistics_poller_wb

Overview:
Wishbone initiator that reads the statistics responder's register file on request and forwards the snapshot as a 32-bit AXI-Stream record. It first checks the presence register, then reads registers 12..48 in address order. Optionally it writes the statistics_reset register afterwards. It sits in the wb_clk domain, between a local trigger source (timer or host command) and a record consumer such as a FIFO or uplink framer.

Parameters:
ACK_TIMEOUT, 255, cycles to wait for wb_ack_i per access before aborting; range 1..65535.
BASE_ADR, 8'h00, responder base address added to every register offset (8-bit wrap).

Ports:
wb_clk  input  1  clock
wb_rst  input  1  synchronous active-high reset
start  input  1  single-cycle sweep request
clear_mask  input  3  statistics_reset value written after a successful sweep; 0 means no write; sampled when start is accepted
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse at sweep end, whether successful or errored
err_code  output  2  0 ok, 1 responder absent, 2 ack timeout; valid from done until the next accepted start
wb_adr_o  output  8  address
wb_dat_o  output  32  write data
wb_we_o  output  1  write enable
wb_stb_o  output  1  strobe
wb_cyc_o  output  1  cycle
wb_dat_i  input  32  read data
wb_ack_i  input  1  acknowledge
m_axis_tdata  output  32  register value
m_axis_tvalid  output  1  valid
m_axis_tready  input  1  ready
m_axis_tlast  output  1  high on the final word (offset 48)

Behaviour:
- Interface: one clock wb_clk; wb_rst is synchronous, active-high.
- Reset: all outputs 0; state IDLE; err_code 0. A reset mid-sweep aborts at once: cyc/stb/tvalid drop on the next edge, no done pulse.
- Bus cycles are Wishbone classic. The initiator drives cyc=stb=1 with adr/we/dat registered and holds them until ack_i is sampled high.
- In the ack cycle the initiator captures wb_dat_i, and cyc/stb go low on the next edge.
- Between accesses cyc/stb stay low for at least 1 cycle. wb_ack_i is ignored while stb_o is low, which absorbs the responder's trailing ack.
- Timeout counter: cleared at each access start. If it reaches ACK_TIMEOUT without an ack, drop cyc/stb, set err_code=2, go to DONE.
- States:
  - IDLE: start accepted when high; latch clear_mask; busy=1; go to PROBE. start while busy is ignored.
  - PROBE: read BASE_ADR+0. Data != 1 -> err_code=1, DONE, nothing streamed. Data == 1 -> READ with offset=12.
  - READ: read BASE_ADR+offset; on ack go to PUSH.
  - PUSH: tvalid=1, tdata=captured value, tlast=(offset==48); hold tdata/tlast stable until tready. On handshake: offset==48 -> CLEAR if mask!=0, else DONE; otherwise offset+=4 -> READ.
  - CLEAR: write BASE_ADR+8 with {29'b0, mask}, we=1; on ack go to DONE.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- A record is exactly 10 words: offsets 12,16,...,48 in order. No partial record is started on a PROBE error. A timeout during READ truncates the record with no tlast, and err_code=2 flags it to downstream.
- Timeout during CLEAR: err_code=2, with the record already complete.
- Latency, zero-wait responder (ack one cycle after stb) and tready tied high: 2 cycles per access + 1 idle + 1 push. Start to done ≤ 50 cycles.
- wb_dat_o=0 and wb_we_o=0 outside CLEAR.

Test Plan:
- Responder model acks after 1 cycle, reg[0]=1, reg[n]=n*16, tready=1; start, clear_mask=0 -> 10 beats: 0xC0,0x100,...,0x300; tlast only on 0x300; no write; done with err_code 0.
- Same setup, tready toggles 1/0 every 3 cycles -> identical data order, tdata/tlast stable while stalled, no beat lost or duplicated.
- reg[0]=0 -> no tvalid, err_code=1, done one cycle after the probe ack.
- Responder never acks offset 28 -> exactly 4 beats (12..24), cyc drops after ACK_TIMEOUT=255 cycles, err_code=2, done pulse.
- clear_mask=3'b101 -> after 10 beats, one write to adr 8 with data 5 and we=1; done follows the write ack; responder ack held 2 cycles -> only one write is counted.
- start pulsed while busy, and wb_rst asserted during the 5th beat -> the second start is ignored; reset gives all outputs 0 next cycle, no done; a new start then gives a full record.
